// File: rtl/match_timer_display_pkg.sv
// Shared definitions for the match clock and future scoreboard blocks.
// State encoding, display constants, the MM:SS BCD time record and its helpers.
// No logic lives here; everything is constants, types and pure functions.
package match_timer_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int NUM_DIGITS = 4;

  // Segment byte with every segment and the dp dark.
  localparam logic [7:0] BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} glyphs for hex digits 0..F, dp dark.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Match time as four BCD digits: minutes tens/ones, seconds tens/ones.
  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } mmss_t;

  localparam mmss_t TIME_ZERO = '0;
  localparam mmss_t TIME_ONE  = '{mt: 4'd0, mo: 4'd0, st: 4'd0, so: 4'd1};

  // Binary minutes/seconds to BCD; used only on elaboration-time constants.
  function automatic mmss_t to_mmss(input int minutes, input int seconds);
    mmss_t t;
    t.mt = 4'(minutes / 10);
    t.mo = 4'(minutes % 10);
    t.st = 4'(seconds / 10);
    t.so = 4'(seconds % 10);
    return t;
  endfunction

  // One-second BCD decrement with borrow so -> st -> mo -> mt.
  // Callers never pass 00:00, so mt never underflows.
  function automatic mmss_t mmss_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.so != 4'd0) begin
      r.so = t.so - 4'd1;
    end else begin
      r.so = 4'd9;
      if (t.st != 4'd0) begin
        r.st = t.st - 4'd1;
      end else begin
        r.st = 4'd5;
        if (t.mo != 4'd0) begin
          r.mo = t.mo - 4'd1;
        end else begin
          r.mo = 4'd9;
          r.mt = t.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/match_timer_display_seg7_decode.sv
// BCD/hex digit to active-low 7-segment glyph, dp left dark.
// Latency: purely combinational, zero cycles.
// No backpressure: a pure function of its input.
module seg7_decode
  import match_timer_display_pkg::*;
(
  input  logic [3:0] digit_dat,
  output logic [7:0] seg_dat
);

  assign seg_dat = SEG_LUT[digit_dat];

endmodule

// File: rtl/match_timer_display.sv
// Match clock: MM:SS BCD countdown paced by tick_1hz, scanned onto a 4-digit active-low 7-seg display.
// Latency: state/time/flags update on the edge sampling a command or tick; an/seg follow a segclk rise by 4 clk edges.
// No backpressure: command pulses and ticks are consumed in the cycle they arrive.
module match_timer_display
  import match_timer_display_pkg::*;
#(
  parameter int START_MIN = 2,
  parameter int START_SEC = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic       segclk,
  input  logic       start,
  input  logic       pause,
  input  logic       restart,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       running,
  output logic       expired
);

  localparam mmss_t START_T = to_mmss(START_MIN, START_SEC);
  localparam bit START_IS_ZERO = (START_T == TIME_ZERO);

  state_e     state_q, state_d;
  mmss_t      time_q, time_d;
  logic       blink_q, blink_d;
  logic       s1_q, s2_q, s3_q;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;

  logic       seg_rise;
  logic [3:0] digit;
  logic [7:0] digit_seg;
  logic       dp_on;
  logic       blank;

  // Command handling, countdown and blink; restart overrides everything.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    blink_d = blink_q;
    if (restart) begin
      state_d = ST_IDLE;
      time_d  = START_T;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = (time_q == TIME_ZERO) ? ST_EXPIRED : ST_RUN;
        end
        ST_RUN: begin
          if (tick_1hz) begin
            // 00:00 cannot normally be seen here; treat it like 00:01 so the time stays legal.
            if (time_q == TIME_ONE || time_q == TIME_ZERO) begin
              time_d  = TIME_ZERO;
              state_d = ST_EXPIRED;
            end else begin
              time_d = mmss_dec(time_q);
            end
          end
          // Pause still lets a coincident tick decrement; expiry on that tick wins.
          if (pause && state_d == ST_RUN) state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (start) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
          if (start) begin
            time_d  = START_T;
            state_d = START_IS_ZERO ? ST_EXPIRED : ST_RUN;
          end else if (tick_1hz) begin
            blink_d = ~blink_q;
          end
        end
      endcase
    end
    // Blink only has meaning while expired; start every expiry with the display lit.
    if (state_d != ST_EXPIRED) blink_d = 1'b0;
  end

  // Digit scan: advance on each synchronized rising edge of segclk.
  always_comb begin
    seg_rise = s2_q & ~s3_q;
    idx_d    = idx_q + {1'b0, seg_rise};
  end

  seg7_decode u_seg7 (
    .digit_dat (digit),
    .seg_dat   (digit_seg)
  );

  // Select the scanned digit, add the MM:SS separator, blank a leading zero and the blink-off phase.
  always_comb begin
    digit = time_q.so;
    an_d  = 4'b1110;
    dp_on = 1'b0;
    blank = 1'b0;
    case (idx_q)
      2'd0: begin
        digit = time_q.so;
        an_d  = 4'b1110;
      end
      2'd1: begin
        digit = time_q.st;
        an_d  = 4'b1101;
      end
      2'd2: begin
        digit = time_q.mo;
        an_d  = 4'b1011;
        dp_on = 1'b1;
      end
      2'd3: begin
        digit = time_q.mt;
        an_d  = 4'b0111;
        blank = (time_q.mt == 4'd0);
      end
    endcase
    seg_d = blank ? BLANK : {~dp_on, digit_seg[6:0]};
    if (state_q == ST_EXPIRED && blink_q) begin
      an_d  = 4'b1111;
      seg_d = BLANK;
    end
  end

  // Status flags decode the next state so they move on the same edge as the state itself.
  always_comb begin
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // State, time and display registers; segclk is treated as asynchronous data (s1/s2 sync, s3 history).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      time_q    <= START_T;
      blink_q   <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1111;
      seg_q     <= BLANK;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      blink_q   <= blink_d;
      s1_q      <= segclk;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_match_timer_display.sv
`timescale 1ns/1ps
module tb_match_timer_display;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic tick_1hz = 1'b0;
  logic segclk = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic restart = 1'b0;

  // Instance 0: 02:00, 1: 01:00, 2: 00:10, 3: 00:00. All share the same stimulus.
  logic [7:0] seg_o     [4];
  logic [3:0] an_o      [4];
  logic       running_o [4];
  logic       expired_o [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  match_timer_display #(.START_MIN(2), .START_SEC(0)) u_dut_2m (
    .clk(clk), .clr(clr), .tick_1hz(tick_1hz), .segclk(segclk), .start(start),
    .pause(pause), .restart(restart), .seg(seg_o[0]), .an(an_o[0]),
    .running(running_o[0]), .expired(expired_o[0]));

  match_timer_display #(.START_MIN(1), .START_SEC(0)) u_dut_1m (
    .clk(clk), .clr(clr), .tick_1hz(tick_1hz), .segclk(segclk), .start(start),
    .pause(pause), .restart(restart), .seg(seg_o[1]), .an(an_o[1]),
    .running(running_o[1]), .expired(expired_o[1]));

  match_timer_display #(.START_MIN(0), .START_SEC(10)) u_dut_10s (
    .clk(clk), .clr(clr), .tick_1hz(tick_1hz), .segclk(segclk), .start(start),
    .pause(pause), .restart(restart), .seg(seg_o[2]), .an(an_o[2]),
    .running(running_o[2]), .expired(expired_o[2]));

  match_timer_display #(.START_MIN(0), .START_SEC(0)) u_dut_0s (
    .clk(clk), .clr(clr), .tick_1hz(tick_1hz), .segclk(segclk), .start(start),
    .pause(pause), .restart(restart), .seg(seg_o[3]), .an(an_o[3]),
    .running(running_o[3]), .expired(expired_o[3]));

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic t, input logic s, input logic p, input logic r);
    tick_1hz = t;
    start    = s;
    pause    = p;
    restart  = r;
    step();
    tick_1hz = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // One segclk rise, held long enough for the an/seg register to follow, then dropped.
  task automatic scan_rise();
    segclk = 1'b1;
    repeat (4) step();
    segclk = 1'b0;
    repeat (3) step();
  endtask

  function automatic logic [3:0] seg_to_digit(input logic [7:0] s);
    case (s)
      8'hC0: return 4'd0;
      8'hF9: return 4'd1;
      8'hA4: return 4'd2;
      8'hB0: return 4'd3;
      8'h99: return 4'd4;
      8'h92: return 4'd5;
      8'h82: return 4'd6;
      8'hF8: return 4'd7;
      8'h80: return 4'd8;
      8'h90: return 4'd9;
      default: return 4'hE;
    endcase
  endfunction

  // Scan all four digits and rebuild MM:SS as BCD; any malformed digit reads as E.
  task automatic read_display(input int inst, output logic [15:0] bcd);
    logic [7:0] s;
    bcd = 16'hEEEE;
    for (int k = 0; k < 4; k++) begin
      scan_rise();
      s = seg_o[inst];
      case (an_o[inst])
        4'b1110: bcd[3:0] = seg_to_digit(s);
        4'b1101: bcd[7:4] = seg_to_digit(s);
        4'b1011: bcd[11:8] = s[7] ? 4'hE : seg_to_digit({1'b1, s[6:0]});
        4'b0111: bcd[15:12] = (s == 8'hFF) ? 4'd0 : ((s == 8'hC0) ? 4'hE : seg_to_digit(s));
        default: ;
      endcase
    end
  endtask

  logic [15:0] disp;
  logic [3:0]  prev_an;
  logic [3:0]  exp_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [7:0]  exp_seg [4] = '{8'hC0, 8'h24, 8'hFF, 8'hC0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (3) step();
    check_eq("rst_an", 16'(an_o[0]), 16'hF);
    check_eq("rst_seg", 16'(seg_o[0]), 16'hFF);
    check_eq("rst_running", 16'(running_o[0]), 16'h0);
    check_eq("rst_expired", 16'(expired_o[0]), 16'h0);
    clr = 1'b1;
    read_display(0, disp);
    check_eq("rst_disp", disp, 16'h0200);

    // Run to 01:37, then reset mid-count.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(23);
    read_display(0, disp);
    check_eq("run_0137", disp, 16'h0137);
    check_eq("run_running", 16'(running_o[0]), 16'h1);
    clr = 1'b0;
    step();
    check_eq("clr_an", 16'(an_o[0]), 16'hF);
    check_eq("clr_seg", 16'(seg_o[0]), 16'hFF);
    check_eq("clr_running", 16'(running_o[0]), 16'h0);
    clr = 1'b1;
    read_display(0, disp);
    check_eq("clr_reload", disp, 16'h0200);
    check_eq("clr_idle_running", 16'(running_o[0]), 16'h0);
    check_eq("clr_idle_expired", 16'(expired_o[0]), 16'h0);

    // Countdown across borrows, START = 01:00.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    read_display(1, disp);
    check_eq("cd_0059", disp, 16'h0059);
    check_eq("cd_running", 16'(running_o[1]), 16'h1);
    ticks(58);
    read_display(1, disp);
    check_eq("cd_0001", disp, 16'h0001);
    check_eq("cd_not_expired", 16'(expired_o[1]), 16'h0);
    ticks(1);
    check_eq("cd_expired_edge", 16'(expired_o[1]), 16'h1);
    check_eq("cd_stopped", 16'(running_o[1]), 16'h0);
    read_display(1, disp);
    check_eq("cd_0000", disp, 16'h0000);

    // Blink in EXPIRED; time stays at 00:00.
    for (int b = 0; b < 2; b++) begin
      ticks(1);
      step();
      check_eq("blink_dark_an", 16'(an_o[1]), 16'hF);
      check_eq("blink_dark_seg", 16'(seg_o[1]), 16'hFF);
      ticks(1);
      read_display(1, disp);
      check_eq("blink_lit_0000", disp, 16'h0000);
    end

    // Start from EXPIRED reloads and runs.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("recov_running", 16'(running_o[1]), 16'h1);
    check_eq("recov_expired", 16'(expired_o[1]), 16'h0);
    read_display(1, disp);
    check_eq("recov_0100", disp, 16'h0100);

    // Pause/resume, START = 00:10.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    read_display(2, disp);
    check_eq("pz_0007", disp, 16'h0007);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("pz_running", 16'(running_o[2]), 16'h0);
    read_display(2, disp);
    check_eq("pz_0006", disp, 16'h0006);
    ticks(5);
    read_display(2, disp);
    check_eq("pz_hold_0006", disp, 16'h0006);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pz_resume_running", 16'(running_o[2]), 16'h1);
    ticks(1);
    read_display(2, disp);
    check_eq("pz_0005", disp, 16'h0005);

    // Scan order, glyphs and 4-edge latency at 02:00.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("scan_start_an", 16'(an_o[0]), 16'hE);
    check_eq("scan_start_seg", 16'(seg_o[0]), 16'hC0);
    prev_an = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      segclk = 1'b1;
      repeat (3) step();
      check_eq("scan_hold_an", 16'(an_o[0]), 16'(prev_an));
      step();
      check_eq("scan_an", 16'(an_o[0]), 16'(exp_an[k]));
      check_eq("scan_seg", 16'(seg_o[0]), 16'(exp_seg[k]));
      segclk = 1'b0;
      repeat (3) step();
      prev_an = exp_an[k];
    end

    // Priority: restart+start+pause together in RUN at 00:30.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(30);
    read_display(1, disp);
    check_eq("pri_0030", disp, 16'h0030);
    pulse(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("pri_running", 16'(running_o[1]), 16'h0);
    check_eq("pri_expired", 16'(expired_o[1]), 16'h0);
    read_display(1, disp);
    check_eq("pri_0100", disp, 16'h0100);
    read_display(0, disp);
    check_eq("pri_0200", disp, 16'h0200);
    check_eq("pri_idle_running", 16'(running_o[0]), 16'h0);

    // IDLE start with START = 00:00 goes straight to EXPIRED.
    check_eq("zero_idle_expired", 16'(expired_o[3]), 16'h0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("zero_expired", 16'(expired_o[3]), 16'h1);
    check_eq("zero_running", 16'(running_o[3]), 16'h0);
    read_display(3, disp);
    check_eq("zero_disp", disp, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
